conv_dot25_calc: RTL and testbench

Pipelined calculation unit that sits directly downstream of the layer controllers (C1/S2, Dense3, …). It consumes one packed `{VecA, VecB, Bias}` word per cycle and computes `sum(VecA[i]*VecB[i]) + Bias` over 25 elements in signed Q8.8. It rounds, saturates and optionally applies ReLU, then returns one 16-bit result per input with a fixed 7-cycle latency. That latency matches the controllers' valid shift register feeding their pooling logic.

---
 rtl/conv_dot25_calc.sv | 170 +++++++++++++++++
 tb/tb_conv_dot25_calc.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_dot25_calc.sv
// conv_dot25_calc: pipelined 25-element signed Q8.8 dot product plus bias.
// Seven register stages: products, a five-level adder tree with the bias
// folded into the last level, then round/saturate/ReLU into the output
// register. Control is a plain valid shift chain, so one set is accepted
// every cycle and results leave in order with a fixed 7-edge latency.
module conv_dot25_calc #(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 8,
  parameter int N       = 25,
  parameter int RELU_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_i,
  input  logic [WIDTH*(2*N+1)-1:0]   data_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  output logic                       sat_o,
  output logic                       busy_o
);

  localparam int DW    = WIDTH * (2 * N + 1);
  localparam int PW    = 2 * WIDTH;
  localparam int ACC_W = 40;

  // Adder tree level sizes. Five pairwise levels reach a single sum for
  // N up to 32; odd levels are padded with a constant-zero slot so every
  // level can be written as a uniform pairwise add.
  localparam int L2 = (N + 1) / 2;
  localparam int L3 = (L2 + 1) / 2;
  localparam int L4 = (L3 + 1) / 2;
  localparam int L5 = (L4 + 1) / 2;

  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (WIDTH - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) << (WIDTH - 1));

  // vld[0] = E1 ... vld[6] = E7 (output register)
  logic [6:0] vld;

  logic signed [WIDTH-1:0] vec_a [2*L2];
  logic signed [WIDTH-1:0] vec_b [2*L2];

  logic signed [PW-1:0]    p1 [2*L2];
  logic signed [ACC_W-1:0] s2 [2*L3];
  logic signed [ACC_W-1:0] s3 [2*L4];
  logic signed [ACC_W-1:0] s4 [2*L5];
  logic signed [ACC_W-1:0] s5 [2];
  logic signed [ACC_W-1:0] s6;
  logic signed [WIDTH-1:0] b1, b2, b3, b4, b5;

  logic signed [ACC_W-1:0] rnd, shr;
  logic                    pos_sat, neg_sat;
  logic [WIDTH-1:0]        res;

  function automatic logic signed [ACC_W-1:0] sx(input logic signed [PW-1:0] x);
    return ACC_W'(x);
  endfunction

  // Unpack operand vectors; element 0 sits at the MSB end of each vector.
  always_comb begin
    for (int i = 0; i < 2*L2; i++) begin
      vec_a[i] = '0;
      vec_b[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      vec_a[i] = data_i[DW-1-WIDTH*i -: WIDTH];
      vec_b[i] = data_i[WIDTH*(N+1)-1-WIDTH*i -: WIDTH];
    end
  end

  // Valid shift chain; the only control state in the unit.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) vld <= '0;
    else       vld <= {vld[5:0], valid_i};
  end

  // E1: element products in Q16.16, bias captured alongside.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < 2*L2; i++) p1[i] <= '0;
      b1 <= '0;
    end else if (valid_i) begin
      for (int i = 0; i < 2*L2; i++) p1[i] <= PW'(vec_a[i]) * PW'(vec_b[i]);
      b1 <= data_i[WIDTH-1:0];
    end
  end

  // E2: first tree level, widened to the accumulator width.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < 2*L3; i++) s2[i] <= '0;
      b2 <= '0;
    end else if (vld[0]) begin
      for (int i = 0; i < L2; i++) s2[i] <= sx(p1[2*i]) + sx(p1[2*i+1]);
      for (int i = L2; i < 2*L3; i++) s2[i] <= '0;
      b2 <= b1;
    end
  end

  // E3: second tree level.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < 2*L4; i++) s3[i] <= '0;
      b3 <= '0;
    end else if (vld[1]) begin
      for (int i = 0; i < L3; i++) s3[i] <= s2[2*i] + s2[2*i+1];
      for (int i = L3; i < 2*L4; i++) s3[i] <= '0;
      b3 <= b2;
    end
  end

  // E4: third tree level.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < 2*L5; i++) s4[i] <= '0;
      b4 <= '0;
    end else if (vld[2]) begin
      for (int i = 0; i < L4; i++) s4[i] <= s3[2*i] + s3[2*i+1];
      for (int i = L4; i < 2*L5; i++) s4[i] <= '0;
      b4 <= b3;
    end
  end

  // E5: fourth tree level.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s5[0] <= '0;
      s5[1] <= '0;
      b5    <= '0;
    end else if (vld[3]) begin
      for (int i = 0; i < L5; i++) s5[i] <= s4[2*i] + s4[2*i+1];
      for (int i = L5; i < 2; i++) s5[i] <= '0;
      b5 <= b4;
    end
  end

  // E6: final sum plus bias promoted from Q8.8 to Q16.16.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)       s6 <= '0;
    else if (vld[4]) s6 <= s5[0] + s5[1] + (ACC_W'(b5) <<< FRAC);
  end

  // Round half toward +inf, saturate to WIDTH, then optional ReLU.
  always_comb begin
    rnd     = s6 + HALF;
    shr     = rnd >>> FRAC;
    pos_sat = (shr > SAT_MAX);
    neg_sat = (shr < SAT_MIN);
    res     = shr[WIDTH-1:0];
    if (pos_sat)      res = {1'b0, {(WIDTH-1){1'b1}}};
    else if (neg_sat) res = {1'b1, {(WIDTH-1){1'b0}}};
    if ((RELU_EN != 0) && res[WIDTH-1]) res = '0;
  end

  // E7: output register; data holds between results, sat_o pulses with valid.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      data_o <= '0;
      sat_o  <= 1'b0;
    end else begin
      sat_o <= vld[5] & (pos_sat | neg_sat);
      if (vld[5]) data_o <= res;
    end
  end

  assign valid_o = vld[6];
  assign busy_o  = |vld;

endmodule

// File: tb/tb_conv_dot25_calc.sv
// Bench for conv_dot25_calc: two instances (ReLU on / off) share stimulus.
// Directed table for the documented corner cases, then streaming, reset
// during streaming and randomized traffic against an arithmetic model.
module tb_conv_dot25_calc;
  localparam int W  = 16;
  localparam int N  = 25;
  localparam int DW = W * (2 * N + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          valid_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          vo_r, so_r, bo_r, vo_n, so_n, bo_n;
  logic [W-1:0]  do_r, do_n;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;
  bit sb_en    = 1'b0;
  logic [W-1:0] last_r = '0;
  logic [W-1:0] last_n = '0;

  typedef struct {
    logic [W-1:0] d_r;
    bit           s_r;
    logic [W-1:0] d_n;
    bit           s_n;
    int           exp_cyc;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           single;
    logic [W-1:0] bias;
    logic [W-1:0] d_r;
    bit           s_r;
    logic [W-1:0] d_n;
    bit           s_n;
  } vec_t;
  vec_t tbl[8];

  conv_dot25_calc #(.WIDTH(16), .FRAC(8), .N(25), .RELU_EN(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
    .valid_o(vo_r), .data_o(do_r), .sat_o(so_r), .busy_o(bo_r));

  conv_dot25_calc #(.WIDTH(16), .FRAC(8), .N(25), .RELU_EN(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
    .valid_o(vo_n), .data_o(do_n), .sat_o(so_n), .busy_o(bo_n));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] pack(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input bit single, input logic [W-1:0] bias);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (!single || i == 0) begin
        d[DW-1-W*i -: W]     = a;
        d[DW-1-W*(N+i) -: W] = b;
      end
    end
    d[W-1:0] = bias;
    return d;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < 26; k++) d = {d[DW-33:0], 32'($urandom())};
    return d;
  endfunction

  // small: never saturates; full: nearly always saturates one way or the other
  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] d;
    bit full;
    full = ($urandom_range(0, 3) == 0);
    d = '0;
    for (int i = 0; i <= 2*N; i++) begin
      if (full) d[DW-1-W*i -: W] = 16'($urandom());
      else      d[DW-1-W*i -: W] = 16'($urandom_range(0, 1023)) - 16'd512;
    end
    return d;
  endfunction

  // Reference: exact integer dot product, floor((x + 0.5 LSB)), clamp, ReLU.
  function automatic void model(input logic [DW-1:0] d, input bit relu,
                                output logic [W-1:0] q, output bit s);
    longint acc, r;
    logic signed [W-1:0] a, b, bi;
    acc = 0;
    for (int i = 0; i < N; i++) begin
      a = d[DW-1-W*i -: W];
      b = d[DW-1-W*(N+i) -: W];
      acc += longint'(a) * longint'(b);
    end
    bi = d[W-1:0];
    acc += longint'(bi) * 256;
    acc += 128;
    if (acc >= 0) r = acc / 256;
    else          r = -((-acc + 255) / 256);
    s = 1'b0;
    if (r > 32767) begin
      r = 32767; s = 1'b1;
    end else if (r < -32768) begin
      r = -32768; s = 1'b1;
    end
    if (relu && r < 0) r = 0;
    q = r[W-1:0];
  endfunction

  function automatic void push(input logic [DW-1:0] d);
    sb_t e;
    model(d, 1'b1, e.d_r, e.s_r);
    model(d, 1'b0, e.d_n, e.s_n);
    e.exp_cyc = cyc + 7;
    sbq.push_back(e);
  endfunction

  // Scoreboard monitor: results must appear exactly on schedule, in order.
  always @(negedge clk) begin
    if (sb_en) begin
      if (vo_r || vo_n) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid", {30'd0, vo_r, vo_n}, 32'd0);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk("sb_valid_r", 32'(vo_r), 32'd1);
          chk("sb_valid_n", 32'(vo_n), 32'd1);
          chk("sb_latency", 32'(cyc), 32'(e.exp_cyc));
          chk("sb_data_r", 32'(do_r), 32'(e.d_r));
          chk("sb_sat_r", 32'(so_r), 32'(e.s_r));
          chk("sb_data_n", 32'(do_n), 32'(e.d_n));
          chk("sb_sat_n", 32'(so_n), 32'(e.s_n));
          last_r = e.d_r;
          last_n = e.d_n;
        end
      end else begin
        chk("hold_data_r", 32'(do_r), 32'(last_r));
        chk("hold_data_n", 32'(do_n), 32'(last_n));
        chk("idle_sat", {30'd0, so_r, so_n}, 32'd0);
        if (sbq.size() > 0 && sbq[0].exp_cyc <= cyc) begin
          chk("missing_valid", 32'd0, 32'd1);
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int lat_r, lat_n, bc, pulses;
    logic [W-1:0] gr, gn;
    bit sr, sn;
    lat_r = -1; lat_n = -1; bc = 0; pulses = 0;
    gr = '0; gn = '0; sr = 1'b0; sn = 1'b0;
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = pack(v.a, v.b, v.single, v.bias);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin
        valid_i = 1'b0;
        data_i  = rand_data();
      end
      if (bo_r) bc++;
      if (vo_r) pulses++;
      if (vo_r && lat_r < 0) begin
        lat_r = i; gr = do_r; sr = so_r;
      end
      if (vo_n && lat_n < 0) begin
        lat_n = i; gn = do_n; sn = so_n;
      end
    end
    chk({v.name, "_lat_r"}, 32'(lat_r), 32'd7);
    chk({v.name, "_lat_n"}, 32'(lat_n), 32'd7);
    chk({v.name, "_pulses"}, 32'(pulses), 32'd1);
    chk({v.name, "_busy_cycles"}, 32'(bc), 32'd7);
    chk({v.name, "_data_r"}, 32'(gr), 32'(v.d_r));
    chk({v.name, "_sat_r"}, 32'(sr), 32'(v.s_r));
    chk({v.name, "_data_n"}, 32'(gn), 32'(v.d_n));
    chk({v.name, "_sat_n"}, 32'(sn), 32'(v.s_n));
    chk({v.name, "_hold_r"}, 32'(do_r), 32'(v.d_r));
    chk({v.name, "_hold_n"}, 32'(do_n), 32'(v.d_n));
  endtask

  initial begin
    tbl[0] = '{"mac",       16'h0100, 16'h0100, 1'b0, 16'h0080, 16'h1980, 1'b0, 16'h1980, 1'b0};
    tbl[1] = '{"neg",       16'h0100, 16'hFF00, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hE700, 1'b0};
    tbl[2] = '{"sat_pos",   16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1};
    tbl[3] = '{"sat_neg",   16'h7FFF, 16'h8000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h8000, 1'b1};
    tbl[4] = '{"rnd_up",    16'h0001, 16'h0080, 1'b1, 16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b0};
    tbl[5] = '{"rnd_half",  16'h0001, 16'hFF80, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[6] = '{"bias_only", 16'h0000, 16'h0000, 1'b0, 16'h1234, 16'h1234, 1'b0, 16'h1234, 1'b0};
    tbl[7] = '{"bias_neg",  16'h0000, 16'h0000, 1'b0, 16'hFF00, 16'h0000, 1'b0, 16'hFF00, 1'b0};

    // Reset state
    @(negedge clk);
    chk("rst_valid", {30'd0, vo_r, vo_n}, 32'd0);
    chk("rst_data", {do_r, do_n}, 32'd0);
    chk("rst_sat", {30'd0, so_r, so_n}, 32'd0);
    chk("rst_busy", {30'd0, bo_r, bo_n}, 32'd0);
    rst_n = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);

    last_r = tbl[7].d_r;
    last_n = tbl[7].d_n;
    sb_en  = 1'b1;

    // Ten back-to-back sets, Bias = 1..10 LSB, vectors zero
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      valid_i = 1'b1;
      data_i  = pack(16'h0, 16'h0, 1'b0, 16'(i));
      push(data_i);
    end
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = rand_data();
    repeat (12) @(negedge clk);
    chk("stream_drain", 32'(sbq.size()), 32'd0);

    // Same stream, reset after the fourth set
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      valid_i = 1'b1;
      data_i  = pack(16'h0, 16'h0, 1'b0, 16'(i));
      push(data_i);
    end
    @(negedge clk);
    valid_i = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    chk("mid_rst_valid", {30'd0, vo_r, vo_n}, 32'd0);
    chk("mid_rst_data", {do_r, do_n}, 32'd0);
    chk("mid_rst_sat", {30'd0, so_r, so_n}, 32'd0);
    chk("mid_rst_busy", {30'd0, bo_r, bo_n}, 32'd0);
    sbq.delete();
    last_r = '0;
    last_n = '0;
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = pack(16'h0100, 16'h0100, 1'b0, 16'h0000);
    @(negedge clk);
    valid_i = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = pack(16'h0, 16'h0, 1'b0, 16'h0005);
    push(data_i);
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = rand_data();
    repeat (12) @(negedge clk);
    chk("post_rst_drain", 32'(sbq.size()), 32'd0);

    // Randomized traffic with gaps and garbage on idle cycles
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      valid_i = ($urandom_range(0, 9) < 7);
      if (valid_i) begin
        data_i = rand_vec();
        push(data_i);
      end else begin
        data_i = rand_data();
      end
    end
    @(negedge clk);
    valid_i = 1'b0;
    repeat (12) @(negedge clk);
    chk("rand_drain", 32'(sbq.size()), 32'd0);
    chk("final_busy", {30'd0, bo_r, bo_n}, 32'd0);

    sb_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
